// File: rtl/dot_channel_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dot_channel_ctrl_pkg
//   Shared definitions for the dot_channel sequencer:
//     DATA_LEN_DEF  default dot-product result width
//     S_IDLE..S_FIN FSM state encoding (3-bit, legacy-compatible constants)
//     dc_dbg_t      debug snapshot of the sequencer (state, bank, guard/timeout count)
//     is_last_bank  true when the bank index is the final bank of a frame
// ---------------------------------------------------------------------------
package dot_channel_ctrl_pkg;

    localparam int DATA_LEN_DEF = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_IN = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    typedef struct packed {
        logic [2:0] state;
        logic [3:0] bank;
        logic [5:0] cnt;
    } dc_dbg_t;

    // The bank counter is only 4 bits wide, so the last bank is detected
    // explicitly instead of relying on a wrap back to 0.
    function automatic logic is_last_bank(input logic [3:0] bank, input int num_cs);
        return bank == 4'(num_cs - 1);
    endfunction

endpackage

// File: rtl/dot_channel_ctrl_result_reg.sv
// ---------------------------------------------------------------------------
// dot_channel_ctrl_result_reg
//   Output holding register for one dot product. A capture loads idx/data and
//   raises out_valid; the value then stays frozen until accept drops out_valid.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     capture               load cap_idx/cap_data, set out_valid
//     cap_idx, cap_data     bank index and dot product to capture
//     accept                downstream took the result (out_valid & out_ready)
//     out_valid             result available
//     out_idx, out_data     held bank index and dot product
// ---------------------------------------------------------------------------
module dot_channel_ctrl_result_reg #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                capture,
    input  logic [3:0]          cap_idx,
    input  logic [DATA_LEN-1:0] cap_data,
    input  logic                accept,
    output logic                out_valid,
    output logic [3:0]          out_idx,
    output logic [DATA_LEN-1:0] out_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= 4'd0;
            out_data  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_idx   <= cap_idx;
            out_data  <= cap_data;
        end else if (accept) begin
            // idx/data are left as they were; only valid is withdrawn.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dot_channel_ctrl.sv
// ---------------------------------------------------------------------------
// dot_channel_ctrl
//   Sequencer for one dot_channel_9 datapath. For a held feature vector it
//   walks the weight bank select through 0..NUM_CS-1, pulses load per bank,
//   waits for the channel's valid and hands each dot product downstream.
//
//   Handshake rules: out_valid rises with a captured result and then holds
//   out_idx/out_data stable until a cycle where out_valid and out_ready are
//   both high; that cycle transfers the result. out_ready while out_valid is
//   low does nothing. Upstream presents in_valid with d stable; in_ready is a
//   single-cycle pulse at frame end telling upstream it may change d.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start                 begin one frame (only looked at in IDLE)
//     in_valid / in_ready   feature vector stable / vector consumed pulse
//     dc_load, dc_cs        load strobe and bank select to the channel
//     dc_valid, dc_q        valid flag and dot product from the channel
//     out_valid/out_ready   result handshake; out_idx/out_data the result
//     busy                  high whenever not IDLE
//     done                  one-cycle pulse after the last bank is accepted
//     err                   sticky timeout flag, cleared by an accepted start
//     dbg                   FSM state, bank and guard/timeout counter
// ---------------------------------------------------------------------------
module dot_channel_ctrl
    import dot_channel_ctrl_pkg::*;
#(
    parameter int NUM_CS   = 9,
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int GUARD    = 2,
    parameter int TIMEOUT  = 63
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                dc_load,
    output logic [3:0]          dc_cs,
    input  logic                dc_valid,
    input  logic [DATA_LEN-1:0] dc_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_idx,
    output logic [DATA_LEN-1:0] out_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output dc_dbg_t             dbg
);

    localparam logic [5:0] GUARD_C   = 6'(GUARD);
    localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);

    logic [2:0] state;
    logic [3:0] bank;
    logic [5:0] cnt;
    logic       capture;
    logic       accept;
    logic       last_bank;

    // A dc_valid seen in the first GUARD RUN cycles is the previous bank's
    // flag still standing; only later ones belong to this load.
    assign capture   = (state == S_RUN) && dc_valid && (cnt >= GUARD_C);
    assign accept    = (state == S_HOLD) && out_ready;
    assign last_bank = is_last_bank(bank, NUM_CS);
    assign busy      = (state != S_IDLE);
    assign dbg       = '{state: state, bank: bank, cnt: cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bank     <= 4'd0;
            cnt      <= 6'd0;
            dc_load  <= 1'b0;
            dc_cs    <= 4'd0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            in_ready <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_WAIT_IN;
                        err   <= 1'b0;
                        bank  <= 4'd0;
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        state   <= S_SETUP;
                        dc_cs   <= bank;
                        dc_load <= 1'b0;
                    end
                end
                S_SETUP: begin
                    // cs has been stable for this whole cycle; raising load
                    // now gives the registered weight read time to settle and
                    // presents a clean 0->1 edge that re-inits the channel.
                    state   <= S_RUN;
                    dc_load <= 1'b1;
                    cnt     <= 6'd0;
                end
                S_RUN: begin
                    if (capture) begin
                        state   <= S_HOLD;
                        dc_load <= 1'b0;
                    end else if (cnt == TIMEOUT_C) begin
                        state   <= S_IDLE;
                        dc_load <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        if (last_bank) begin
                            state    <= S_FIN;
                            in_ready <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            state <= S_SETUP;
                            bank  <= bank + 4'd1;
                            dc_cs <= bank + 4'd1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    dc_load <= 1'b0;
                end
            endcase
        end
    end

    dot_channel_ctrl_result_reg #(
        .DATA_LEN (DATA_LEN)
    ) u_result (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .cap_idx   (bank),
        .cap_data  (dc_q),
        .accept    (accept),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_dot_channel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dot_channel_ctrl
//   Frame-level bench for dot_channel_ctrl. A behavioural channel model
//   raises valid a fixed number of cycles after load rises (optionally with a
//   stale valid at the start of RUN) and returns a q derived from the frame
//   number and the bank it was given. Results are checked against an
//   expected queue built from the frame/bank rules alone.
// ---------------------------------------------------------------------------
module tb_dot_channel_ctrl;
    import dot_channel_ctrl_pkg::*;

    localparam int NUM_CS = 9;
    localparam int DL     = DATA_LEN_DEF;

    // ---------------- clock / reset ----------------
    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          dc_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [DL-1:0] dc_q      = '0;
    logic          in_ready, dc_load, out_valid, busy, done, err;
    logic [3:0]    dc_cs, out_idx;
    logic [DL-1:0] out_data;
    dc_dbg_t       dbg;

    always #5 clk = ~clk;

    dot_channel_ctrl #(
        .NUM_CS   (NUM_CS),
        .DATA_LEN (DL),
        .GUARD    (2),
        .TIMEOUT  (63)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dc_load   (dc_load),
        .dc_cs     (dc_cs),
        .dc_valid  (dc_valid),
        .dc_q      (dc_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg       (dbg)
    );

    // ---------------- scoreboard ----------------
    int               n_vec = 0;
    int               n_err = 0;
    logic [DL+3:0]    exp_q[$];   // {idx, data}
    int               frame_id = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DL-1:0] model_q(input int f, input int b);
        logic [31:0] h;
        h = (32'(f) * 32'h9E37_79B1) ^ (32'(b) * 32'h0100_0193) ^ 32'h00C0_FFEE;
        return DL'(h);
    endfunction

    // ---------------- frame vectors ----------------
    typedef struct {
        int lat;         // load-high cycles until the channel raises valid
        int stale;       // leading load-high cycles with a stale valid
        int bp_idx;      // bank whose result sees out_ready held low
        int bp_len;      // number of HOLD cycles with out_ready low
        int iv_delay;    // cycles in WAIT_IN before in_valid rises
        int busy_start;  // cycle at which start is pulsed mid-frame (-1 none)
        int rst_bank;    // reset during this bank's RUN (-1 none)
        bit dead;        // channel never raises valid
        bit rnd_ready;   // random out_ready
        int exp_busy;    // busy cycles for the frame (-1 skip)
        int exp_res;     // results transferred
        int exp_done;    // done / in_ready pulses
        bit exp_err;     // err at frame end
    } frame_vec_t;

    function automatic frame_vec_t mk(input int lat, stale, bp_idx, bp_len, iv_delay,
                                      busy_start, rst_bank, input bit dead, rnd_ready,
                                      input int exp_busy, exp_res, exp_done, input bit exp_err);
        frame_vec_t v;
        v.lat = lat; v.stale = stale; v.bp_idx = bp_idx; v.bp_len = bp_len;
        v.iv_delay = iv_delay; v.busy_start = busy_start; v.rst_bank = rst_bank;
        v.dead = dead; v.rnd_ready = rnd_ready; v.exp_busy = exp_busy;
        v.exp_res = exp_res; v.exp_done = exp_done; v.exp_err = exp_err;
        return v;
    endfunction

    int r_busy, r_done, r_inr, r_res;

    // ---------------- driver: one frame ----------------
    task automatic run_frame(input frame_vec_t v);
        int lcnt, hold_cnt, n_res, cyc;
        bit fin;
        exp_q.delete();
        frame_id++;
        if (!v.dead)
            for (int b = 0; b < NUM_CS; b++) exp_q.push_back({4'(b), model_q(frame_id, b)});
        r_busy = 0; r_done = 0; r_inr = 0;
        lcnt = 0; hold_cnt = 0; n_res = 0; fin = 1'b0;

        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (!busy) begin
                fin = 1'b1;
            end else begin
                r_busy++;
                if (done) r_done++;
                if (in_ready) begin r_inr++; in_valid = 1'b0; end
                if (cyc == v.iv_delay) in_valid = 1'b1;
                if (cyc < v.iv_delay) check("load_low_wait_in", 64'(dc_load), 64'(0));
                start = (cyc == v.busy_start);

                // channel model
                if (dc_load) begin
                    if (lcnt == 0) check("cs_at_load", 64'(dc_cs), 64'(n_res));
                    lcnt++;
                end else begin
                    lcnt = 0;
                end
                dc_valid = !v.dead && ((lcnt >= 1 && lcnt <= v.stale) || lcnt >= v.lat);
                dc_q = (lcnt >= v.lat) ? model_q(frame_id, int'(dc_cs))
                                       : ~model_q(frame_id, int'(dc_cs));

                if (v.rst_bank >= 0 && n_res == v.rst_bank && lcnt == 3) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_in_ready",  64'(in_ready),  64'(0));
                    check("rst_dc_load",   64'(dc_load),   64'(0));
                    check("rst_dc_cs",     64'(dc_cs),     64'(0));
                    check("rst_out_valid", 64'(out_valid), 64'(0));
                    check("rst_out_idx",   64'(out_idx),   64'(0));
                    check("rst_out_data",  64'(out_data),  64'(0));
                    check("rst_busy",      64'(busy),      64'(0));
                    check("rst_done",      64'(done),      64'(0));
                    fin = 1'b1;
                end else begin
                    if (v.rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
                    else out_ready = !(n_res == v.bp_idx && hold_cnt < v.bp_len);

                    if (out_valid) begin
                        check("load_low_in_hold", 64'(dc_load), 64'(0));
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", 64'(1), 64'(0));
                        end else begin
                            check("out_idx",  64'(out_idx),  64'(exp_q[0][DL+3:DL]));
                            check("out_data", 64'(out_data), 64'(exp_q[0][DL-1:0]));
                            if (out_ready) begin
                                void'(exp_q.pop_front());
                                n_res++;
                                hold_cnt = 0;
                            end else begin
                                hold_cnt++;
                            end
                        end
                    end
                end
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) check("frame_cycle_budget", 64'(0), 64'(1));
        start = 1'b0; in_valid = 1'b0; dc_valid = 1'b0; out_ready = 1'b1;
        if (!rst_n) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
        r_res = n_res;
    endtask

    // ---------------- test sequence ----------------
    frame_vec_t tbl[10];

    initial begin
        //              lat st bpi bpl ivd bst rst dead rnd  busy res done err
        tbl[0] = mk(13, 0, -1, 0,  0, -1, -1, 0, 0, 137, 9, 1, 0);  // nominal
        tbl[1] = mk(13, 0,  3, 5,  0, -1, -1, 0, 0, 142, 9, 1, 0);  // backpressure idx 3
        tbl[2] = mk(13, 2, -1, 0,  0, -1, -1, 0, 0, 137, 9, 1, 0);  // stale valid
        tbl[3] = mk( 3, 2, -1, 0,  0, -1, -1, 0, 0,  47, 9, 1, 0);  // valid at first unguarded cycle
        tbl[4] = mk(13, 0, -1, 0,  0, -1, -1, 1, 0,  66, 0, 0, 1);  // timeout
        tbl[5] = mk(13, 0, -1, 0,  0, -1, -1, 0, 0, 137, 9, 1, 0);  // err cleared by start
        tbl[6] = mk(13, 0, -1, 0, 10, 40, -1, 0, 0, 147, 9, 1, 0);  // late in_valid, start while busy
        tbl[7] = mk(20, 1,  8, 3,  0, -1, -1, 0, 0, 203, 9, 1, 0);  // long latency, stall on last bank
        tbl[8] = mk(13, 0, -1, 0,  0, -1,  5, 0, 0,  -1, 5, 0, 0);  // reset in bank 5 RUN
        tbl[9] = mk(13, 0, -1, 0,  0, -1, -1, 0, 0, 137, 9, 1, 0);  // clean frame after reset

        #1 rst_n = 1'b0;
        #1;
        check("reset_dc_load",   64'(dc_load),   64'(0));
        check("reset_dc_cs",     64'(dc_cs),     64'(0));
        check("reset_in_ready",  64'(in_ready),  64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_idx",   64'(out_idx),   64'(0));
        check("reset_out_data",  64'(out_data),  64'(0));
        check("reset_busy",      64'(busy),      64'(0));
        check("reset_done",      64'(done),      64'(0));
        check("reset_err",       64'(err),       64'(0));
        check("reset_state",     64'(dbg.state), 64'(S_IDLE));
        check("reset_bank",      64'(dbg.bank),  64'(0));
        check("reset_cnt",       64'(dbg.cnt),   64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i]);
            if (tbl[i].exp_busy >= 0)
                check($sformatf("busy_cycles[%0d]", i), 64'(r_busy), 64'(tbl[i].exp_busy));
            check($sformatf("results[%0d]", i),  64'(r_res),  64'(tbl[i].exp_res));
            check($sformatf("done[%0d]", i),     64'(r_done), 64'(tbl[i].exp_done));
            check($sformatf("in_ready[%0d]", i), 64'(r_inr),  64'(tbl[i].exp_done));
            check($sformatf("err[%0d]", i),      64'(err),    64'(tbl[i].exp_err));
            check($sformatf("idle_busy[%0d]", i), 64'(busy),  64'(0));
            repeat (2) @(negedge clk);
        end

        // randomized frames: latency, stale flag, in_valid delay and out_ready
        for (int i = 0; i < 16; i++) begin
            frame_vec_t v;
            v = mk(int'($urandom_range(3, 20)), int'($urandom_range(0, 2)), -1, 0,
                   int'($urandom_range(0, 3)), -1, -1, 0, 1, -1, 9, 1, 0);
            run_frame(v);
            check($sformatf("rnd_results[%0d]", i),  64'(r_res),  64'(9));
            check($sformatf("rnd_done[%0d]", i),     64'(r_done), 64'(1));
            check($sformatf("rnd_in_ready[%0d]", i), 64'(r_inr),  64'(1));
            check($sformatf("rnd_err[%0d]", i),      64'(err),    64'(0));
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
